switch_entry_ctrl: RTL and testbench

User-input front end for the lab board: debounces one push-button, walks the user through a two-press entry sequence, and issues a single-cycle immediate-load command to the register file/ALU (dest select, then 8-bit value). It is the input-side counterpart of the display path and drives the same regEn/muxA/muxB/muxBimm/Opcode command interface as the sequencing FSM; the top level selects between the two sources.

---
 rtl/switch_entry_ctrl_pkg.sv | 27 ++
 rtl/switch_entry_ctrl_btn_debounce.sv | 45 ++++
 rtl/switch_entry_ctrl.sv | 92 +++++++++
 tb/tb_switch_entry_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/switch_entry_ctrl_pkg.sv
// Shared constants and types for the push-button immediate-load entry path.
// The ALU opcode set is shared with the sequencing FSM that drives the same command bus.
package switch_entry_ctrl_pkg;

  localparam int REG_COUNT = 16;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h10;
  localparam logic [7:0] OP_SUB  = 8'h20;
  localparam logic [7:0] OP_AND  = 8'h30;
  localparam logic [7:0] OP_OR   = 8'h40;
  localparam logic [7:0] OP_MOVI = 8'hD0;

  typedef enum logic [1:0] {
    SEL_DST = 2'd0,
    SEL_VAL = 2'd1,
    WRITE   = 2'd2
  } entry_state_t;

  function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [3:0] idx);
    logic [REG_COUNT-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/switch_entry_ctrl_btn_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for an active-low button.
// Emits a single-cycle press_pulse on each accepted released-to-pressed change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_a;
  logic          sync_b;
  logic          level_n;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_a      <= 1'b1;
      sync_b      <= 1'b1;
      level_n     <= 1'b1;
      count       <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync_a      <= btn_n;
      sync_b      <= sync_a;
      press_pulse <= 1'b0;
      // Any cycle that agrees with the accepted level restarts the count.
      if (sync_b != level_n) begin
        if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_n     <= sync_b;
          count       <= '0;
          press_pulse <= ~sync_b;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/switch_entry_ctrl.sv
// Two-press entry sequencer: first press picks the destination register, second
// press captures the immediate and issues one load-immediate write on the command bus.
//
// state   | meaning
// SEL_DST | waiting for the destination press (phase = 0)
// SEL_VAL | destination latched, waiting for the value press (phase = 1)
// WRITE   | single write cycle on regEn/muxA/muxBimm/Opcode
module switch_entry_ctrl
  import switch_entry_ctrl_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter logic [7:0] MOVI_OPCODE     = OP_MOVI
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_n,
  input  logic [7:0]           sw,
  output logic [REG_COUNT-1:0] regEn,
  output logic [3:0]           muxA,
  output logic [3:0]           muxB,
  output logic                 muxBimm,
  output logic [7:0]           Opcode,
  output logic [7:0]           imm8,
  output logic [3:0]           dst,
  output logic                 phase,
  output logic                 wr_done
);

  entry_state_t state;
  logic         press_pulse;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .press_pulse(press_pulse)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= SEL_DST;
      regEn   <= '0;
      muxA    <= '0;
      muxB    <= '0;
      muxBimm <= 1'b0;
      Opcode  <= '0;
      imm8    <= '0;
      dst     <= '0;
      phase   <= 1'b0;
      wr_done <= 1'b0;
    end else begin
      // Command bus is idle unless the transition below opens a write cycle.
      regEn   <= '0;
      muxA    <= '0;
      muxB    <= '0;
      muxBimm <= 1'b0;
      Opcode  <= '0;
      wr_done <= 1'b0;
      case (state)
        SEL_DST: begin
          if (press_pulse) begin
            dst   <= sw[3:0];
            phase <= 1'b1;
            state <= SEL_VAL;
          end
        end
        SEL_VAL: begin
          if (press_pulse) begin
            imm8    <= sw;
            regEn   <= reg_onehot(dst);
            muxA    <= dst;
            muxBimm <= 1'b1;
            Opcode  <= MOVI_OPCODE;
            wr_done <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          phase <= 1'b0;
          state <= SEL_DST;
        end
        default: begin
          phase <= 1'b0;
          state <= SEL_DST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_entry_ctrl.sv
// Bench for switch_entry_ctrl with a short debounce window: directed scenarios
// followed by random button/switch traffic, all checked against a behavioural model.
module tb_switch_entry_ctrl;

  localparam int D = 4;
  localparam logic [7:0] MOVI = 8'hD0;

  logic        clk;
  logic        rst;
  logic        btn_n;
  logic [7:0]  sw;
  logic [15:0] regEn;
  logic [3:0]  muxA;
  logic [3:0]  muxB;
  logic        muxBimm;
  logic [7:0]  Opcode;
  logic [7:0]  imm8;
  logic [3:0]  dst;
  logic        phase;
  logic        wr_done;

  switch_entry_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .sw(sw),
    .regEn(regEn), .muxA(muxA), .muxB(muxB), .muxBimm(muxBimm),
    .Opcode(Opcode), .imm8(imm8), .dst(dst), .phase(phase), .wr_done(wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: button samples delayed two edges, a run length of
  // disagreeing samples, and a two-press sequence producing one write.
  bit          dly[$];
  int          run;
  bit          deb_rel;
  bit          pulse_q;
  bit          m_phase;
  bit          m_write;
  logic [3:0]  m_dst;
  logic [7:0]  m_imm;

  int          wr_cnt;
  logic [15:0] last_reg;
  logic [7:0]  last_imm;

  task automatic model_reset();
    dly = '{1'b1, 1'b1};
    run = 0; deb_rel = 1'b1; pulse_q = 1'b0;
    m_phase = 1'b0; m_write = 1'b0; m_dst = '0; m_imm = '0;
  endtask

  task automatic model_edge(input bit b, input logic [7:0] s, input bit r);
    bit lvl;
    bit seen;
    bit new_pulse;
    if (!r) begin
      model_reset();
    end else begin
      seen = pulse_q;
      new_pulse = 1'b0;
      lvl = dly.pop_front();
      dly.push_back(b);
      if (lvl != deb_rel) begin
        run++;
        if (run == D) begin
          deb_rel = lvl;
          run = 0;
          new_pulse = !lvl;
        end
      end else begin
        run = 0;
      end
      pulse_q = new_pulse;
      if (m_write) begin
        m_write = 1'b0;
        m_phase = 1'b0;
      end else if (seen) begin
        if (!m_phase) begin
          m_dst = s[3:0];
          m_phase = 1'b1;
        end else begin
          m_imm = s;
          m_write = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit b, input logic [7:0] s, input bit r);
    @(negedge clk);
    btn_n = b; sw = s; rst = r;
    @(posedge clk);
    model_edge(b, s, r);
    #1;
    check_val("regEn", 32'(regEn), m_write ? 32'(16'h1 << m_dst) : 32'h0);
    check_val("muxA_muxB", {24'h0, muxA, muxB}, m_write ? {24'h0, m_dst, 4'h0} : 32'h0);
    check_val("imm_ctl", {23'h0, muxBimm, Opcode}, m_write ? {23'h0, 1'b1, MOVI} : 32'h0);
    check_val("wr_done", 32'(wr_done), 32'(m_write));
    check_val("dst_phase", {27'h0, dst, phase}, {27'h0, m_dst, m_phase});
    check_val("imm8", 32'(imm8), 32'(m_imm));
    if (wr_done) begin
      wr_cnt++;
      last_reg = regEn;
      last_imm = imm8;
    end
  endtask

  task automatic press(input logic [7:0] s, input int hold);
    for (int i = 0; i < hold; i++) step(1'b0, s, 1'b1);
    for (int i = 0; i < D + 4; i++) step(1'b1, s, 1'b1);
  endtask

  int          lat;
  int          base;
  logic [15:0] exp_reg [3];
  logic [7:0]  exp_imm [3];

  initial begin
    rst = 1'b0; btn_n = 1'b1; sw = 8'h00;
    wr_cnt = 0; last_reg = '0; last_imm = '0;
    model_reset();

    // Reset with the button toggling.
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    check_val("rst_regEn", 32'(regEn), 32'h0);
    check_val("rst_phase", 32'(phase), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b1);

    // Basic entry.
    press(8'h05, 10);
    check_val("basic_dst", 32'(dst), 32'h5);
    check_val("basic_phase", 32'(phase), 32'h1);
    press(8'hF3, 10);
    check_val("basic_wr_cnt", 32'(wr_cnt), 32'd1);
    check_val("basic_regEn", 32'(last_reg), 32'h0020);
    check_val("basic_imm8", 32'(last_imm), 32'hF3);
    check_val("basic_phase0", 32'(phase), 32'h0);

    // Glitches shorter than the debounce window.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h11, 1'b1);
    step(1'b1, 8'h11, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 8'h11, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h11, 1'b1);
    check_val("glitch_phase", 32'(phase), 32'h0);
    check_val("glitch_wr_cnt", 32'(wr_cnt), 32'd1);

    // Long hold: one accepted press, latency from the first low sample.
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      step(1'b0, (lat != 0) ? 8'hAA : 8'h0A, 1'b1);
      if (lat == 0 && phase) lat = i;
    end
    check_val("hold_latency", 32'(lat), 32'(D + 3));
    check_val("hold_dst", 32'(dst), 32'hA);
    check_val("hold_phase", 32'(phase), 32'h1);
    for (int i = 0; i < D + 4; i++) step(1'b1, 8'hAA, 1'b1);

    // Reset mid-sequence.
    step(1'b1, 8'h00, 1'b0);
    press(8'h0F, 8);
    check_val("mid_dst15", 32'(dst), 32'hF);
    step(1'b1, 8'h0F, 1'b0);
    check_val("mid_rst_dst", 32'(dst), 32'h0);
    check_val("mid_rst_phase", 32'(phase), 32'h0);
    base = wr_cnt;
    press(8'h3C, 8);
    check_val("mid_no_write", 32'(wr_cnt - base), 32'd0);
    check_val("mid_phase", 32'(phase), 32'h1);
    step(1'b1, 8'h00, 1'b0);
    press(8'h0F, 8);
    press(8'h3C, 8);
    check_val("r15_regEn", 32'(last_reg), 32'h8000);
    check_val("r15_wr_cnt", 32'(wr_cnt - base), 32'd1);

    // Back-to-back sequences.
    exp_reg = '{16'h0001, 16'h0080, 16'h8000};
    exp_imm = '{8'h00, 8'h7F, 8'h80};
    base = wr_cnt;
    for (int k = 0; k < 3; k++) begin
      press({4'h0, (k == 0) ? 4'h0 : (k == 1) ? 4'h7 : 4'hF}, 7);
      press(exp_imm[k], 7);
      check_val("b2b_regEn", 32'(last_reg), 32'(exp_reg[k]));
      check_val("b2b_imm8", 32'(last_imm), 32'(exp_imm[k]));
    end
    check_val("b2b_wr_cnt", 32'(wr_cnt - base), 32'd3);

    // Random traffic with occasional resets.
    for (int n = 0; n < 250; n++) begin
      logic [7:0] s;
      int hold;
      int gap;
      s    = 8'($urandom);
      hold = int'($urandom_range(1, 12));
      gap  = int'($urandom_range(1, 12));
      for (int i = 0; i < hold; i++) step(1'b0, (i == hold / 2) ? 8'($urandom) : s, 1'b1);
      for (int i = 0; i < gap; i++) step(1'b1, s, ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
